// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - load/store stage: op decode, req/ack bus access, core stall,
// lane-shifted load return, misalignment and bus-timeout detection.
module mem_access_unit #(
   parameter int TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [5:0]  cuOP,
   input  logic [31:0] aluOut,
   input  logic [31:0] storeData,
   output logic        stall,
   output logic [31:0] memload,
   output logic        fault,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [3:0]  mem_be,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata,
   input  logic        mem_ack
);

   localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

   localparam logic [5:0] OP_LB  = 6'd10;
   localparam logic [5:0] OP_LH  = 6'd11;
   localparam logic [5:0] OP_LW  = 6'd12;
   localparam logic [5:0] OP_LBU = 6'd13;
   localparam logic [5:0] OP_LHU = 6'd14;
   localparam logic [5:0] OP_SB  = 6'd15;
   localparam logic [5:0] OP_SH  = 6'd16;
   localparam logic [5:0] OP_SW  = 6'd17;

   localparam logic [1:0] SZ_BYTE = 2'd0;
   localparam logic [1:0] SZ_HALF = 2'd1;
   localparam logic [1:0] SZ_WORD = 2'd2;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ACCESS = 2'd1,
      S_DONE   = 2'd2,
      S_FAULT  = 2'd3
   } state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [1:0]    size_q, size_d;
   logic [1:0]    off_q, off_d;
   logic [31:0]   memload_q, memload_d;
   logic          mem_req_q, mem_req_d;
   logic          mem_we_q, mem_we_d;
   logic [31:0]   mem_addr_q, mem_addr_d;
   logic [3:0]    mem_be_q, mem_be_d;
   logic [31:0]   mem_wdata_q, mem_wdata_d;

   logic          is_mem;
   logic          is_store;
   logic [1:0]    size;
   logic          misaligned;
   logic [3:0]    be;
   logic [31:0]   wdata;
   logic [31:0]   rd_shift;
   logic [31:0]   lane;

   always_comb begin
      is_mem   = 1'b1;
      is_store = 1'b0;
      size     = SZ_BYTE;
      case (cuOP)
         OP_LB, OP_LBU: size = SZ_BYTE;
         OP_LH, OP_LHU: size = SZ_HALF;
         OP_LW:         size = SZ_WORD;
         OP_SB: begin size = SZ_BYTE; is_store = 1'b1; end
         OP_SH: begin size = SZ_HALF; is_store = 1'b1; end
         OP_SW: begin size = SZ_WORD; is_store = 1'b1; end
         default:       is_mem = 1'b0;
      endcase

      misaligned = ((size == SZ_HALF) && aluOut[0]) ||
                   ((size == SZ_WORD) && (aluOut[1:0] != 2'b00));

      case (size)
         SZ_BYTE: begin
            be    = 4'b0001 << aluOut[1:0];
            wdata = {4{storeData[7:0]}};
         end
         SZ_HALF: begin
            be    = aluOut[1] ? 4'b1100 : 4'b0011;
            wdata = {2{storeData[15:0]}};
         end
         default: begin
            be    = 4'b1111;
            wdata = storeData;
         end
      endcase
   end

   // Lane selection uses the offset latched at issue, not the live aluOut.
   always_comb begin
      rd_shift = mem_rdata >> {off_q, 3'b000};
      case (size_q)
         SZ_BYTE: lane = {24'b0, rd_shift[7:0]};
         SZ_HALF: lane = {16'b0, off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0]};
         default: lane = mem_rdata;
      endcase
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      size_d      = size_q;
      off_d       = off_q;
      memload_d   = memload_q;
      mem_req_d   = mem_req_q;
      mem_we_d    = mem_we_q;
      mem_addr_d  = mem_addr_q;
      mem_be_d    = mem_be_q;
      mem_wdata_d = mem_wdata_q;
      stall       = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (is_mem) begin
               stall = 1'b1;
               if (misaligned) begin
                  state_d   = S_FAULT;
                  memload_d = 32'b0;
               end else begin
                  state_d     = S_ACCESS;
                  cnt_d       = '0;
                  size_d      = size;
                  off_d       = aluOut[1:0];
                  mem_req_d   = 1'b1;
                  mem_we_d    = is_store;
                  mem_addr_d  = {aluOut[31:2], 2'b00};
                  mem_be_d    = be;
                  mem_wdata_d = wdata;
               end
            end
         end
         S_ACCESS: begin
            stall = 1'b1;
            if (mem_ack) begin
               state_d   = S_DONE;
               mem_req_d = 1'b0;
               if (!mem_we_q) memload_d = lane;
            end else if (cnt_q == CNT_LAST) begin
               state_d   = S_FAULT;
               mem_req_d = 1'b0;
               memload_d = 32'b0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         size_q      <= SZ_BYTE;
         off_q       <= 2'b00;
         memload_q   <= 32'b0;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= 32'b0;
         mem_be_q    <= 4'b0;
         mem_wdata_q <= 32'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         size_q      <= size_d;
         off_q       <= off_d;
         memload_q   <= memload_d;
         mem_req_q   <= mem_req_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_be_q    <= mem_be_d;
         mem_wdata_q <= mem_wdata_d;
      end
   end

   assign fault     = (state_q == S_FAULT);
   assign memload   = memload_q;
   assign mem_req   = mem_req_q;
   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_be    = mem_be_q;
   assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - directed scoreboard bench for mem_access_unit (TIMEOUT=4).
module tb_mem_access_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic [5:0]  cuOP;
   logic [31:0] aluOut;
   logic [31:0] storeData;
   logic        stall;
   logic [31:0] memload;
   logic        fault;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [3:0]  mem_be;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic        mem_ack;

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [3:0]  be;
      logic [31:0] wdata;
   } bus_t;

   bus_t        bus_q[$];
   logic [31:0] load_q[$];
   int          vectors = 0;
   int          miscompares = 0;

   localparam logic [5:0] ADD = 6'd28;

   mem_access_unit #(.TIMEOUT(4)) dut (
      .clk(clk), .rst(rst), .cuOP(cuOP), .aluOut(aluOut), .storeData(storeData),
      .stall(stall), .memload(memload), .fault(fault), .mem_req(mem_req),
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .mem_ack(mem_ack)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Drives one op at a negedge, acks on the ack_at-th ACCESS cycle, then checks
   // the popped bus record and load result.
   task automatic mem_op(input string tag, input logic [5:0] op, input logic [31:0] addr,
                         input logic [31:0] sdata, input logic [31:0] rdata, input int ack_at);
      int   n_stall;
      bit   done;
      bus_t b;
      logic [31:0] exp_load;
      cuOP = op; aluOut = addr; storeData = sdata; mem_rdata = rdata; mem_ack = 1'b0;
      n_stall = 0;
      done = 0;
      for (int c = 0; c < 30 && !done; c++) begin
         #1;
         if (stall) begin
            n_stall++;
            if (n_stall == 2) begin
               b = bus_q.pop_front();
               chk({tag, "_req"},   {31'b0, mem_req}, 32'd1);
               chk({tag, "_we"},    {31'b0, mem_we},  {31'b0, b.we});
               chk({tag, "_addr"},  mem_addr,         b.addr);
               chk({tag, "_be"},    {28'b0, mem_be},  {28'b0, b.be});
               if (b.we) chk({tag, "_wdata"}, mem_wdata, b.wdata);
            end
            mem_ack = (n_stall == ack_at + 1);
            @(negedge clk);
         end else begin
            done = 1;
         end
      end
      chk({tag, "_done"}, {31'b0, done}, 32'd1);
      chk({tag, "_stall_cycles"}, n_stall, ack_at + 1);
      exp_load = load_q.pop_front();
      chk({tag, "_memload"}, memload, exp_load);
      chk({tag, "_fault"}, {31'b0, fault}, 32'd0);
      chk({tag, "_req_low"}, {31'b0, mem_req}, 32'd0);
      mem_ack = 1'b0;
      cuOP = ADD;
      @(negedge clk);
   endtask

   initial begin
      int req_cycles;
      bit saw_fault;

      rst = 1'b1; cuOP = ADD; aluOut = 32'h0; storeData = 32'h0;
      mem_rdata = 32'h0; mem_ack = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         mem_ack = 1'($urandom_range(0, 1));
      end
      rst = 1'b0;
      mem_ack = 1'b0;
      #1;
      chk("rst_stall",   {31'b0, stall},   32'd0);
      chk("rst_memload", memload,          32'd0);
      chk("rst_fault",   {31'b0, fault},   32'd0);
      chk("rst_req",     {31'b0, mem_req}, 32'd0);
      chk("rst_we",      {31'b0, mem_we},  32'd0);
      chk("rst_addr",    mem_addr,         32'd0);
      chk("rst_be",      {28'b0, mem_be},  32'd0);
      chk("rst_wdata",   mem_wdata,        32'd0);
      @(negedge clk);

      bus_q.push_back('{we: 1'b0, addr: 32'h100, be: 4'b1111, wdata: 32'h0});
      load_q.push_back(32'hDEADBEEF);
      mem_op("lw", 6'd12, 32'h100, 32'h0, 32'hDEADBEEF, 2);

      bus_q.push_back('{we: 1'b0, addr: 32'h200, be: 4'b1000, wdata: 32'h0});
      load_q.push_back(32'h00000080);
      mem_op("lb", 6'd10, 32'h203, 32'h0, 32'h80112233, 1);

      bus_q.push_back('{we: 1'b1, addr: 32'h300, be: 4'b1100, wdata: 32'hABCDABCD});
      load_q.push_back(32'h00000080);
      mem_op("sh", 6'd16, 32'h302, 32'h1234ABCD, 32'hFFFFFFFF, 1);

      bus_q.push_back('{we: 1'b0, addr: 32'h100, be: 4'b1100, wdata: 32'h0});
      load_q.push_back(32'h0000CAFE);
      mem_op("lhu", 6'd14, 32'h102, 32'h0, 32'hCAFE1234, 3);

      bus_q.push_back('{we: 1'b1, addr: 32'h000, be: 4'b0010, wdata: 32'hA5A5A5A5});
      load_q.push_back(32'h0000CAFE);
      mem_op("sb", 6'd15, 32'h001, 32'h000000A5, 32'h0, 1);

      // Misaligned word load: one stall cycle, one fault cycle, no request.
      cuOP = 6'd12; aluOut = 32'h101;
      #1;
      chk("mis_stall", {31'b0, stall},   32'd1);
      @(negedge clk); #1;
      chk("mis_fault",   {31'b0, fault},   32'd1);
      chk("mis_stall2",  {31'b0, stall},   32'd0);
      chk("mis_memload", memload,          32'd0);
      chk("mis_req",     {31'b0, mem_req}, 32'd0);
      cuOP = ADD;
      @(negedge clk); #1;
      chk("mis_fault_off", {31'b0, fault}, 32'd0);
      @(negedge clk);

      // Word store with no ack: times out after TIMEOUT request cycles.
      cuOP = 6'd17; aluOut = 32'h400; storeData = 32'h55AA00FF; mem_ack = 1'b0;
      req_cycles = 0;
      saw_fault = 0;
      for (int c = 0; c < 20 && !saw_fault; c++) begin
         @(negedge clk); #1;
         if (mem_req) req_cycles++;
         if (fault) begin
            saw_fault = 1;
            chk("to_stall", {31'b0, stall}, 32'd0);
         end
      end
      chk("to_fault_seen", {31'b0, saw_fault}, 32'd1);
      chk("to_req_cycles", req_cycles, 32'd4);
      cuOP = ADD;
      @(negedge clk);
      mem_ack = 1'b1;
      mem_rdata = 32'h12345678;
      @(negedge clk); #1;
      mem_ack = 1'b0;
      chk("late_ack_req",     {31'b0, mem_req}, 32'd0);
      chk("late_ack_fault",   {31'b0, fault},   32'd0);
      chk("late_ack_memload", memload,          32'd0);
      chk("late_ack_stall",   {31'b0, stall},   32'd0);
      @(negedge clk);

      // Reset mid-access, then a clean byte load.
      cuOP = 6'd13; aluOut = 32'h501; mem_ack = 1'b0;
      @(negedge clk); #1;
      chk("rsta_req_up", {31'b0, mem_req}, 32'd1);
      rst = 1'b1;
      @(negedge clk); #1;
      chk("rsta_req_drop", {31'b0, mem_req}, 32'd0);
      rst = 1'b0;
      cuOP = ADD;
      mem_ack = 1'b1;
      @(negedge clk); #1;
      mem_ack = 1'b0;
      chk("rsta_late_ack", {31'b0, mem_req}, 32'd0);
      chk("rsta_memload",  memload,          32'd0);
      @(negedge clk);

      bus_q.push_back('{we: 1'b0, addr: 32'h500, be: 4'b0010, wdata: 32'h0});
      load_q.push_back(32'h00000033);
      mem_op("lbu", 6'd13, 32'h501, 32'h0, 32'h11223344, 1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
Load/store stage directly upstream of the writeback mux. Decodes load/store cuOP values, issues one request per instruction to data memory over a req/ack handshake, and stalls the core until the access completes. Returns load data lane-shifted into memload bits [7:0]/[15:0]/[31:0], ready for writeback sign/zero extension. Also detects misaligned accesses and bus timeouts.

Parameters:
TIMEOUT, 16, maximum cycles in ACCESS without mem_ack before FAULT (>=1)

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
cuOP  in  6  decoded op; LB=10 LH=11 LW=12 LBU=13 LHU=14 SB=15 SH=16 SW=17, all others non-memory
aluOut  in  32  effective byte address
storeData  in  32  rs2 value
stall  out  1  freeze PC/pipeline this cycle
memload  out  32  lane-shifted load data, registered
fault  out  1  one-cycle pulse: misaligned access or timeout
mem_req  out  1  bus request, registered
mem_we  out  1  1=write, registered
mem_addr  out  32  word address {aluOut[31:2],2'b00}, registered
mem_be  out  4  byte enables, registered
mem_wdata  out  32  lane-replicated store data, registered
mem_rdata  in  32  read data, valid with mem_ack
mem_ack  in  1  one-cycle completion strobe

Behaviour:
- Reset (clk edge with rst=1): state IDLE; memload=0, mem_req=0, mem_we=0, mem_addr=0, mem_be=0, mem_wdata=0, fault=0, timeout counter=0. Reset mid-ACCESS drops mem_req at that edge; late acks are ignored.
- States: IDLE, ACCESS, DONE, FAULT.
- IDLE: for a memory op, stall=1 combinationally.
  - Aligned: next ACCESS. Load registers mem_req=1, mem_we (1 for SB/SH/SW), mem_addr, mem_be, mem_wdata.
  - Misaligned: next FAULT, no request. Misaligned = LH/LHU/SH with addr[0]=1; LW/SW with addr[1:0]!=0.
  - Non-memory op: stall=0, stay IDLE.
- ACCESS: stall=1; bus outputs held stable; counter increments each cycle.
  - mem_ack=1: capture memload, mem_req=0 at that edge, go DONE.
  - Counter reaches TIMEOUT-1 with no ack: mem_req=0, go FAULT.
  - mem_ack outside ACCESS is ignored.
- DONE: stall=0, memload valid; the core advances at this edge. Next IDLE. Minimum access latency is 3 cycles: IDLE, ACCESS with ack in the first ACCESS cycle, DONE.
- FAULT: stall=0, fault=1, memload=0; next IDLE.
- Byte enables: SB=4'b0001<<addr[1:0]; SH=addr[1]?4'b1100:4'b0011; SW=4'b1111; loads use the same mask.
- Write data: SB={4{storeData[7:0]}}; SH={2{storeData[15:0]}}; SW=storeData.
- Load capture:
  - LB/LBU: memload={24'b0, byte addr[1:0] of rdata}.
  - LH/LHU: memload={16'b0, half addr[1] of rdata}.
  - LW: memload=rdata.
  - No extension is done here; extension belongs to writeback.
- memload holds its value until the next captured load or FAULT.
- cuOP and aluOut are guaranteed stable while stall=1. The unit latches the op at IDLE and does not re-sample it.
- Counter clears on entry to ACCESS.

Test Plan:
- Reset with random mem_ack toggling -> all outputs 0, state IDLE, stall=0 for cuOP=28 (ADD).
- LW, aluOut=0x100, mem_rdata=0xDEADBEEF, ack on the 2nd ACCESS cycle:
  - stall=1 for 3 cycles, then DONE with stall=0.
  - mem_addr=0x100, mem_be=4'b1111, mem_we=0.
  - memload=0xDEADBEEF.
- LB, aluOut=0x203, mem_rdata=0x80112233 -> mem_addr=0x200, mem_be=4'b1000, memload=0x00000080.
- SH, aluOut=0x302, storeData=0x1234ABCD -> mem_we=1, mem_be=4'b1100, mem_wdata=0xABCDABCD, mem_addr=0x300.
- LW, aluOut=0x101 -> no mem_req; fault=1 for exactly one cycle, memload=0, stall high 1 cycle.
- SW with mem_ack held 0, TIMEOUT=4:
  - mem_req high exactly 4 cycles, then FAULT with fault=1.
  - A late ack in the following IDLE has no effect.
- rst=1 during ACCESS -> mem_req=0 at the next edge; a subsequent LBU completes normally.
